// File: rtl/uncache_dm.sv
// -----------------------------------------------------------------------------
// uncache_dm
//   Uncached data-memory access engine for the MEM stage. It takes one MEM1
//   request at a time (the uncached window, Paddr[31:16] == 16'h1faf). For
//   each request it issues one single-beat read or write on the uncache side
//   of the data-memory bus mux. Load data is returned to MEM2 on rdata.
//
//   Build option:
//     UNCACHE_WBUF_EN  - when defined, a one-entry posted-write buffer drives
//                        the write channel. A store completes as soon as it is
//                        parked in the buffer, and loads wait until the buffer
//                        has drained, so a read never overtakes a buffered
//                        write. When undefined, a store completes only when
//                        the bus accepts it, and wb_empty is tied high.
//
//   Ports:
//     clk, rst                  clock, synchronous active-low reset
//     valid/op/addr/size/
//       wstrb/wdata             MEM1 request; valid is held until accepted
//     data_ok                   engine free (IDLE, no request) or completion
//                               pulse (one cycle per accepted request)
//     rdata                     last completed load result
//     rd_req/rd_type/rd_addr/
//       rd_rdy                  bus read request channel
//     ret_valid/ret_last/
//       ret_data                bus read return channel
//     wr_req/wr_type/wr_addr/
//       wr_wstrb/wr_data/wr_rdy bus write request channel
//     wb_empty                  posted-write buffer empty
// -----------------------------------------------------------------------------
module uncache_dm #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,

    // MEM1 request side
    input  logic          valid,
    input  logic          op,
    input  logic [AW-1:0] addr,
    input  logic [1:0]    size,
    input  logic [3:0]    wstrb,
    input  logic [DW-1:0] wdata,
    output logic          data_ok,
    output logic [DW-1:0] rdata,

    // bus read channel
    output logic          rd_req,
    output logic [2:0]    rd_type,
    output logic [AW-1:0] rd_addr,
    input  logic          rd_rdy,
    input  logic          ret_valid,
    input  logic          ret_last,
    input  logic [DW-1:0] ret_data,

    // bus write channel
    output logic          wr_req,
    output logic [2:0]    wr_type,
    output logic [AW-1:0] wr_addr,
    output logic [3:0]    wr_wstrb,
    output logic [DW-1:0] wr_data,
    input  logic          wr_rdy,
    output logic          wb_empty
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state, state_nxt;

    // Latched request; the MEM1 inputs may change once the request is taken.
    logic [AW-1:0] req_addr;
    logic [1:0]    req_size;
    logic [3:0]    req_wstrb;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] rdata_q;

    logic accept;
    logic rd_fire;
    logic ret_done;

    // DONE doubles as an accept state so back-to-back requests skip IDLE.
    assign accept   = valid && ((state == IDLE) || (state == DONE));
    assign rd_fire  = rd_req && rd_rdy;
    assign ret_done = (state == RD_WAIT) && ret_valid && ret_last;

`ifdef UNCACHE_WBUF_EN
    // ------------------------------------------------------------------
    // One-entry posted-write buffer
    // ------------------------------------------------------------------
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [1:0]    wb_size;
    logic [3:0]    wb_wstrb;
    logic [DW-1:0] wb_data;
    logic          wb_free;
    logic          wb_load_new;
    logic          wb_load_held;

    // The slot is usable this cycle if empty or if its entry is being
    // accepted by the bus right now.
    assign wb_free      = !wb_valid || wr_rdy;
    // A store at accept time writes the slot straight from the MEM1 inputs;
    // a store that had to wait in WR_REQ writes it from the latched copy.
    assign wb_load_new  = accept && op && wb_free;
    assign wb_load_held = (state == WR_REQ) && wb_free;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_size  <= '0;
            wb_wstrb <= '0;
            wb_data  <= '0;
        end else if (wb_load_new) begin
            wb_valid <= 1'b1;
            wb_addr  <= addr;
            wb_size  <= size;
            wb_wstrb <= wstrb;
            wb_data  <= wdata;
        end else if (wb_load_held) begin
            wb_valid <= 1'b1;
            wb_addr  <= req_addr;
            wb_size  <= req_size;
            wb_wstrb <= req_wstrb;
            wb_data  <= req_wdata;
        end else if (wb_valid && wr_rdy) begin
            wb_valid <= 1'b0;
        end
    end

    assign wr_req   = wb_valid;
    assign wr_type  = {1'b0, wb_size};
    assign wr_addr  = wb_addr;
    assign wr_wstrb = wb_wstrb;
    assign wr_data  = wb_data;
    assign wb_empty = !wb_valid;

    // A load holds off while a write is still buffered.
    assign rd_req   = (state == RD_REQ) && !wb_valid;
`else
    // ------------------------------------------------------------------
    // Direct write channel: the store itself is the bus request
    // ------------------------------------------------------------------
    assign wr_req   = (state == WR_REQ);
    assign wr_type  = {1'b0, req_size};
    assign wr_addr  = req_addr;
    assign wr_wstrb = req_wstrb;
    assign wr_data  = req_wdata;
    assign wb_empty = 1'b1;

    assign rd_req   = (state == RD_REQ);
`endif

    assign rd_type = {1'b0, req_size};
    assign rd_addr = req_addr;
    assign rdata   = rdata_q;

    // Free when idle with nothing pending, and a one-cycle completion pulse
    // in DONE. The first term makes this combinational from valid.
    assign data_ok = ((state == IDLE) && !valid) || (state == DONE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_nxt gets a default before the case so that no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (valid) begin
                    if (op) begin
`ifdef UNCACHE_WBUF_EN
                        state_nxt = wb_free ? DONE : WR_REQ;
`else
                        state_nxt = WR_REQ;
`endif
                    end else begin
                        state_nxt = RD_REQ;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            RD_REQ: begin
                if (rd_fire) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Non-last beats are dropped; only the last beat completes.
                if (ret_valid && ret_last) begin
                    state_nxt = DONE;
                end
            end
            WR_REQ: begin
`ifdef UNCACHE_WBUF_EN
                if (wb_free) begin
                    state_nxt = DONE;
                end
`else
                // The write counts as complete once the bus accepts it.
                if (wr_rdy) begin
                    state_nxt = DONE;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and load result
    // ------------------------------------------------------------------
    // NOTE: these are plain data flops, not a memory array. They are reset
    // so that bus outputs read zero out of reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_addr  <= '0;
            req_size  <= '0;
            req_wstrb <= '0;
            req_wdata <= '0;
        end else if (accept) begin
            req_addr  <= addr;
            req_size  <= size;
            req_wstrb <= wstrb;
            req_wdata <= wdata;
        end
    end

    // rdata keeps the last load result; stores leave it alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (ret_done) begin
            rdata_q <= ret_data;
        end
    end

    // ------------------------------------------------------------------
    // Bus protocol properties
    // ------------------------------------------------------------------
    a_no_overlap : assert property (@(posedge clk) disable iff (!rst)
        !(rd_req && wr_req));

    a_rd_stable : assert property (@(posedge clk) disable iff (!rst)
        (rd_req && !rd_rdy) |=> (rd_req && $stable(rd_addr) && $stable(rd_type)));

endmodule

// File: tb/tb_uncache_dm.sv
// -----------------------------------------------------------------------------
// tb_uncache_dm
//   Self-checking bench for uncache_dm. Each request is run as a transaction.
//   Expectations come from the protocol rules: the latency from accept to
//   the bus request, outputs held stable while the bus stalls, a single DONE
//   pulse, and rdata persisting until the next load. The last load value is
//   the only state the bench keeps.
// -----------------------------------------------------------------------------
module tb_uncache_dm;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid = 1'b0;
    logic          op = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [1:0]    size = '0;
    logic [3:0]    wstrb = '0;
    logic [DW-1:0] wdata = '0;
    logic          data_ok;
    logic [DW-1:0] rdata;
    logic          rd_req;
    logic [2:0]    rd_type;
    logic [AW-1:0] rd_addr;
    logic          rd_rdy = 1'b0;
    logic          ret_valid = 1'b0;
    logic          ret_last = 1'b0;
    logic [DW-1:0] ret_data = '0;
    logic          wr_req;
    logic [2:0]    wr_type;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_wstrb;
    logic [DW-1:0] wr_data;
    logic          wr_rdy = 1'b0;
    logic          wb_empty;

    int            n_tests = 0;
    int            n_fails = 0;
    logic [DW-1:0] exp_rdata = '0;

    uncache_dm #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .op        (op),
        .addr      (addr),
        .size      (size),
        .wstrb     (wstrb),
        .wdata     (wdata),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data),
        .wr_req    (wr_req),
        .wr_type   (wr_type),
        .wr_addr   (wr_addr),
        .wr_wstrb  (wr_wstrb),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy),
        .wb_empty  (wb_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs are driven at 1 time unit after the posedge. Outputs are
    // checked 1 unit later, well away from both clock edges.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Load transaction. Starts in an IDLE or DONE cycle, ends in its DONE cycle.
    task automatic do_load(input bit in_done, input logic [31:0] a, input logic [1:0] s,
                           input logic [31:0] d, input int stall, input int gap,
                           output bit ended_done);
        valid = 1'b1; op = 1'b0; addr = a; size = s;
        wstrb = 4'($urandom); wdata = $urandom;
        #1;
        check("ld_accept_data_ok", data_ok, in_done);
        check("ld_accept_rd_req", rd_req, 0);
        cyc();
        // Scramble the request inputs: the engine must use its latched copy.
        valid = 1'b0; addr = $urandom; size = 2'($urandom_range(0, 2));
        for (int i = 0; i <= stall; i++) begin
            rd_rdy    = (i == stall);
            ret_valid = 1'($urandom_range(0, 1));
            ret_last  = 1'($urandom_range(0, 1));
            ret_data  = $urandom;
            #1;
            check("ld_rd_req", rd_req, 1);
            check("ld_rd_addr", rd_addr, a);
            check("ld_rd_type", rd_type, {1'b0, s});
            check("ld_no_wr_req", wr_req, 0);
            check("ld_busy_data_ok", data_ok, 0);
            check("ld_rdata_hold", rdata, exp_rdata);
            cyc();
        end
        rd_rdy = 1'b0;
        for (int i = 0; i < gap; i++) begin
            ret_valid = 1'($urandom_range(0, 1));
            ret_last  = 1'b0;
            ret_data  = $urandom;
            #1;
            check("ld_wait_rd_req", rd_req, 0);
            check("ld_wait_data_ok", data_ok, 0);
            check("ld_wait_rdata", rdata, exp_rdata);
            cyc();
        end
        ret_valid = 1'b1; ret_last = 1'b1; ret_data = d;
        #1;
        check("ld_ret_data_ok", data_ok, 0);
        cyc();
        ret_valid = 1'b0; ret_last = 1'b0; ret_data = $urandom;
        exp_rdata = d;
        #1;
        check("ld_done_data_ok", data_ok, 1);
        check("ld_done_rdata", rdata, exp_rdata);
        check("ld_done_rd_req", rd_req, 0);
        ended_done = 1'b1;
    endtask

    // Store transaction. Ends in DONE (direct write) or in IDLE once the
    // posted write has drained (buffered build).
    task automatic do_store(input bit in_done, input logic [31:0] a, input logic [1:0] s,
                            input logic [3:0] st, input logic [31:0] d, input int stall,
                            output bit ended_done);
        valid = 1'b1; op = 1'b1; addr = a; size = s; wstrb = st; wdata = d;
        #1;
        check("st_accept_data_ok", data_ok, in_done);
        check("st_accept_wr_req", wr_req, 0);
        cyc();
        valid = 1'b0; addr = $urandom; size = 2'($urandom_range(0, 2));
        wstrb = 4'($urandom); wdata = $urandom;
`ifdef UNCACHE_WBUF_EN
        wr_rdy = 1'b0;
        #1;
        check("st_posted_data_ok", data_ok, 1);
        check("st_posted_wr_req", wr_req, 1);
        check("st_posted_wb_empty", wb_empty, 0);
        cyc();
        for (int i = 0; i <= stall; i++) begin
            wr_rdy = (i == stall);
            #1;
            check("st_wr_req", wr_req, 1);
            check("st_wr_addr", wr_addr, a);
            check("st_wr_type", wr_type, {1'b0, s});
            check("st_wr_wstrb", wr_wstrb, st);
            check("st_wr_data", wr_data, d);
            check("st_no_rd_req", rd_req, 0);
            cyc();
        end
        wr_rdy = 1'b0;
        #1;
        check("st_drained_wr_req", wr_req, 0);
        check("st_drained_wb_empty", wb_empty, 1);
        ended_done = 1'b0;
`else
        for (int i = 0; i <= stall; i++) begin
            wr_rdy = (i == stall);
            #1;
            check("st_wr_req", wr_req, 1);
            check("st_wr_addr", wr_addr, a);
            check("st_wr_type", wr_type, {1'b0, s});
            check("st_wr_wstrb", wr_wstrb, st);
            check("st_wr_data", wr_data, d);
            check("st_no_rd_req", rd_req, 0);
            check("st_busy_data_ok", data_ok, 0);
            cyc();
        end
        wr_rdy = 1'b0;
        #1;
        check("st_done_data_ok", data_ok, 1);
        check("st_done_wr_req", wr_req, 0);
        check("st_done_rdata", rdata, exp_rdata);
        check("st_wb_empty", wb_empty, 1);
        ended_done = 1'b1;
`endif
    endtask

    // Return to IDLE, then check that a stray return beat is ignored.
    task automatic go_idle(input bit from_done);
        valid = 1'b0;
        if (from_done) cyc();
        #1;
        check("idle_data_ok", data_ok, 1);
        ret_valid = 1'b1; ret_last = 1'b1; ret_data = $urandom;
        cyc();
        ret_valid = 1'b0; ret_last = 1'b0;
        #1;
        check("idle_stray_rdata", rdata, exp_rdata);
        check("idle_stray_data_ok", data_ok, 1);
        check("idle_rd_req", rd_req, 0);
        check("idle_wr_req", wr_req, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        bit            ended;
        bit            in_done;
        logic [31:0]   a;
        logic [31:0]   d;
        logic [1:0]    s;

        // Reset, held for two cycles with no request.
        rst = 1'b0;
        cyc();
        cyc();
        #1;
        check("rst_data_ok", data_ok, 1);
        check("rst_rd_req", rd_req, 0);
        check("rst_wr_req", wr_req, 0);
        check("rst_rdata", rdata, 0);
        check("rst_wb_empty", wb_empty, 1);
        rst = 1'b1;
        cyc();

        // Word load with a zero-wait bus: data_ok and rdata at accept+3.
        do_load(1'b0, 32'h1faf_f020, 2'b10, 32'hdead_beef, 0, 0, ended);
        go_idle(ended);

        // Byte store with wr_rdy low for three cycles.
        do_store(1'b0, 32'h1faf_f003, 2'b00, 4'b1000, 32'h5500_0000, 3, ended);
        go_idle(ended);

        // Back-to-back loads: the second is accepted during the first's DONE.
        do_load(1'b0, 32'h1faf_0100, 2'b10, 32'h1111_2222, 1, 1, ended);
        do_load(ended, 32'h1faf_0202, 2'b01, 32'h3333_4444, 0, 2, ended);
        go_idle(ended);

        // Reset while in RD_WAIT drops the load; a later return is ignored.
        valid = 1'b1; op = 1'b0; addr = 32'h1faf_0300; size = 2'b10;
        #1;
        cyc();
        valid = 1'b0; rd_rdy = 1'b1;
        #1;
        check("rstw_rd_req", rd_req, 1);
        cyc();
        rd_rdy = 1'b0;
        #1;
        check("rstw_wait_rd_req", rd_req, 0);
        check("rstw_wait_data_ok", data_ok, 0);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        exp_rdata = '0;
        #1;
        check("rstw_data_ok", data_ok, 1);
        check("rstw_rd_req_after", rd_req, 0);
        check("rstw_rdata", rdata, exp_rdata);
        ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'h1234_5678;
        cyc();
        ret_valid = 1'b0; ret_last = 1'b0;
        #1;
        check("rstw_stray_rdata", rdata, exp_rdata);
        check("rstw_stray_data_ok", data_ok, 1);

`ifdef UNCACHE_WBUF_EN
        // A posted store completes at accept+1. A following load must hold
        // rd_req low until the bus has accepted the buffered write.
        valid = 1'b1; op = 1'b1; addr = 32'h1faf_0400; size = 2'b10;
        wstrb = 4'hf; wdata = 32'hcafe_f00d; wr_rdy = 1'b0;
        #1;
        cyc();
        #1;
        check("wb_st_data_ok", data_ok, 1);
        check("wb_st_wr_req", wr_req, 1);
        valid = 1'b1; op = 1'b0; addr = 32'h1faf_0500; size = 2'b10;
        #1;
        cyc();
        valid = 1'b0; rd_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("wb_ld_blocked", rd_req, 0);
            check("wb_wr_pending", wr_req, 1);
            cyc();
        end
        wr_rdy = 1'b1;
        #1;
        check("wb_ld_blocked_last", rd_req, 0);
        check("wb_wr_accept", wr_req, 1);
        cyc();
        wr_rdy = 1'b0;
        #1;
        check("wb_wr_gone", wr_req, 0);
        check("wb_ld_go", rd_req, 1);
        check("wb_ld_addr", rd_addr, 32'h1faf_0500);
        cyc();
        rd_rdy = 1'b0; ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'h0bad_cafe;
        #1;
        cyc();
        ret_valid = 1'b0; ret_last = 1'b0;
        exp_rdata = 32'h0bad_cafe;
        #1;
        check("wb_ld_data_ok", data_ok, 1);
        check("wb_ld_rdata", rdata, exp_rdata);
        go_idle(1'b1);
`endif

        // Randomized mix of loads and stores, with random stalls, junk
        // beats, back-to-back issue and idle gaps.
        in_done = 1'b0;
        repeat (250) begin
            a = {16'h1faf, 16'($urandom)};
            s = 2'($urandom_range(0, 2));
            d = $urandom;
            if ($urandom_range(0, 1) == 1)
                do_store(in_done, a, s, 4'($urandom), d, $urandom_range(0, 3), ended);
            else
                do_load(in_done, a, s, d, $urandom_range(0, 3), $urandom_range(0, 3), ended);
            if (ended && ($urandom_range(0, 2) != 0)) begin
                in_done = 1'b1;
            end else begin
                go_idle(ended);
                in_done = 1'b0;
            end
        end
        go_idle(in_done);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
